// File: rtl/oq_header_parser.sv
// Snoops output-queue writes, extracts per-packet destination and length into a FWFT FIFO.
// Optional OQ_HDR_PARSER_STATS_EN adds header/error counters.
module oq_header_parser #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8,
  parameter int NUM_OUTPUT_QUEUES = 5,
  parameter int PKT_LEN_WIDTH = 11,
  parameter int PKT_WORDS_WIDTH = PKT_LEN_WIDTH - $clog2(CTRL_WIDTH),
  parameter int NUM_OQ_WIDTH = $clog2(NUM_OUTPUT_QUEUES),
  parameter logic [CTRL_WIDTH-1:0] IO_QUEUE_STAGE_NUM = 8'hFF,
  parameter int DST_FIFO_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DATA_WIDTH-1:0]      in_data,
  input  logic [CTRL_WIDTH-1:0]      in_ctrl,
  input  logic                       in_wr,
  output logic                       in_rdy,
  output logic                       dst_oq_avail,
  output logic [NUM_OQ_WIDTH-1:0]    parsed_dst_oq,
  output logic [PKT_LEN_WIDTH-1:0]   parsed_pkt_byte_len,
  output logic [PKT_WORDS_WIDTH-1:0] parsed_pkt_word_len,
  input  logic                       rd_dst_oq,
  output logic                       hdr_err,
  output logic                       fifo_overflow
`ifdef OQ_HDR_PARSER_STATS_EN
  ,
  output logic [15:0]                num_hdrs_parsed,
  output logic [15:0]                num_hdr_errs
`endif
);

  localparam int AW = $clog2(DST_FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_WAIT_HDR = 2'b01,
    ST_WAIT_EOP = 2'b10
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   r_prev0;
  logic   w_prev0_nxt;
  logic   w_push;

  logic                       w_hdr_ok;
  logic [NUM_OUTPUT_QUEUES-1:0] w_onehot;
  logic [NUM_OQ_WIDTH-1:0]    w_dst_oq;
  logic [NUM_OQ_WIDTH-1:0]    w_push_dst;
  logic [PKT_LEN_WIDTH-1:0]   w_push_blen;
  logic [PKT_WORDS_WIDTH-1:0] w_push_wlen;

  logic [NUM_OQ_WIDTH-1:0]    r_dst_mem  [DST_FIFO_DEPTH];
  logic [PKT_LEN_WIDTH-1:0]   r_blen_mem [DST_FIFO_DEPTH];
  logic [PKT_WORDS_WIDTH-1:0] r_wlen_mem [DST_FIFO_DEPTH];
  logic [AW-1:0]              r_wr_ptr;
  logic [AW-1:0]              r_rd_ptr;
  logic [AW:0]                r_count;
  logic                       r_hdr_err;
  logic                       r_ovf;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_wr_en;
  logic w_ovf;
  logic w_unused;

  assign w_unused = ^in_data;

  assign w_hdr_ok = (in_ctrl == IO_QUEUE_STAGE_NUM);
  assign w_onehot = in_data[48 +: NUM_OUTPUT_QUEUES];

  // Lowest set bit wins; scanning downward lets it overwrite higher hits
  always_comb begin
    w_dst_oq = '0;
    for (int i = NUM_OUTPUT_QUEUES - 1; i >= 0; i--) begin
      if (w_onehot[i]) w_dst_oq = NUM_OQ_WIDTH'(i);
    end
  end

  assign w_push_dst  = w_hdr_ok ? w_dst_oq : '0;
  assign w_push_blen = w_hdr_ok ? in_data[PKT_LEN_WIDTH-1:0] : '0;
  assign w_push_wlen = w_hdr_ok ? in_data[32 +: PKT_WORDS_WIDTH] : '0;

  always_comb begin
    w_state_nxt = r_state;
    w_prev0_nxt = r_prev0;
    w_push      = 1'b0;
    case (r_state)
      ST_WAIT_HDR: begin
        if (in_wr) begin
          w_push      = 1'b1;
          w_prev0_nxt = 1'b0;
          w_state_nxt = ST_WAIT_EOP;
        end
      end
      ST_WAIT_EOP: begin
        if (in_wr) begin
          if (r_prev0 && (in_ctrl != '0)) begin
            w_state_nxt = ST_WAIT_HDR;
            w_prev0_nxt = 1'b0;
          end else begin
            w_prev0_nxt = (in_ctrl == '0);
          end
        end
      end
      default: begin
        w_state_nxt = ST_WAIT_HDR;
        w_prev0_nxt = 1'b0;
      end
    endcase
  end

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == (AW+1)'(DST_FIFO_DEPTH));
  assign w_pop   = rd_dst_oq && !w_empty;
  // A full FIFO still takes the push when the head leaves the same cycle
  assign w_wr_en = w_push && (!w_full || w_pop);
  assign w_ovf   = w_push && w_full && !w_pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_WAIT_HDR;
      r_prev0   <= 1'b0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_hdr_err <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_prev0   <= w_prev0_nxt;
      r_hdr_err <= w_push && !w_hdr_ok;
      r_ovf     <= w_ovf;
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr_en, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_dst_mem[r_wr_ptr]  <= w_push_dst;
      r_blen_mem[r_wr_ptr] <= w_push_blen;
      r_wlen_mem[r_wr_ptr] <= w_push_wlen;
    end
  end

  assign in_rdy              = (r_state == ST_WAIT_EOP) || !w_full;
  assign dst_oq_avail        = !w_empty;
  assign parsed_dst_oq       = w_empty ? '0 : r_dst_mem[r_rd_ptr];
  assign parsed_pkt_byte_len = w_empty ? '0 : r_blen_mem[r_rd_ptr];
  assign parsed_pkt_word_len = w_empty ? '0 : r_wlen_mem[r_rd_ptr];
  assign hdr_err             = r_hdr_err;
  assign fifo_overflow       = r_ovf;

`ifdef OQ_HDR_PARSER_STATS_EN
  logic [15:0] r_num_hdrs;
  logic [15:0] r_num_errs;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_num_hdrs <= '0;
      r_num_errs <= '0;
    end else if (w_push) begin
      if (w_hdr_ok) r_num_hdrs <= r_num_hdrs + 1'b1;
      else          r_num_errs <= r_num_errs + 1'b1;
    end
  end

  assign num_hdrs_parsed = r_num_hdrs;
  assign num_hdr_errs    = r_num_errs;
`else
`endif

endmodule
